mul3_seq_ctrl: RTL and testbench
================================

Name: mul3_seq_ctrl

Overview:
Sequencing controller for the 12-bit triple-operand datapath. It synchronises the asynchronous start strobe e, captures operands a/b/c, and computes y = a*b*c on one shared 12-step shift-add multiplier over two passes. It presents a 40-bit result with a one-cycle valid pulse. It sits between the top-level operand/strobe inputs and the y output of module_top.

Parameters:
W, 12, operand width of a, b, c
YW, 40, result width; must be >= 3*W
SYNC_STAGES, 2, flip-flop stages in the e synchroniser (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
e  input  1  start strobe, asynchronous to clk; a rising edge requests one computation
a  input  W  operand A; sampled only on the accepted start edge
b  input  W  operand B; same sampling rule
c  input  W  operand C; same sampling rule
y  output  YW  last completed product a*b*c, zero-extended
valid  output  1  one-cycle pulse when y updates
busy  output  1  high from the cycle after the start edge is accepted through the DONE cycle
drop  output  1  one-cycle pulse when a start edge arrives while busy

Behaviour:
- Reset (async, rst=1): state=IDLE; y=0, valid=0, busy=0, drop=0; all synchroniser flops, counters and accumulators cleared. Reset mid-computation aborts it; no valid is issued.
- Synchroniser: e passes through SYNC_STAGES flops, then one extra flop. start_edge = sync_out & ~delayed. start_edge is high for exactly one cycle per e rising edge, SYNC_STAGES+1 posedges after e is first sampled high. Glitches shorter than one clock may be missed (accepted).
- IDLE: busy=0. On start_edge, capture a,b,c into a_r,b_r,c_r. Clear acc1 (2W bits), acc2 (3W bits) and cnt. Go to MUL1.
- MUL1 (W cycles, cnt=0..W-1): if b_r[cnt], acc1 += a_r << cnt. At cnt=W-1, clear cnt and go to MUL2.
- MUL2 (W cycles): if c_r[cnt], acc2 += acc1 << cnt. At cnt=W-1, go to DONE.
- DONE (1 cycle): y <= zero-extend(acc2) to YW, registered on entry so y is visible in DONE. valid=1 this cycle only. Next state is IDLE.
- Latency: start_edge in IDLE at cycle N -> MUL1 N+1..N+W -> MUL2 N+W+1..N+2W -> DONE at N+2W+1 (N+25 for W=12), with valid=1 and new y there.
- Arithmetic: unsigned. acc1 max (2^W-1)^2 fits 2W bits. acc2 max fits 3W bits. No overflow is possible. Bits YW-1..3W of y are always 0.
- Back-to-back: a start_edge during DONE is treated as busy (dropped). A start_edge in the first IDLE cycle after DONE is accepted.
- drop: pulses for start_edge while state != IDLE. The running computation is unaffected.
- y holds its value between results and across dropped requests. a/b/c changing while busy has no effect.

Decomposition:
- Shared package: state encoding constants (S_IDLE, S_MUL1, S_MUL2, S_DONE), default W/YW, counter width clog2(W).
- Sub-module: sync_edge_det (parameter SYNC_STAGES; ports clk, rst, d, rise). Multi-flop synchroniser plus rising-edge pulse; reusable for other async strobes.
- Counter, accumulators and FSM stay in mul3_seq_ctrl.

Test Plan:
- Reset mid-run: assert rst during MUL2 -> y=0, busy=0, valid=0 immediately; no valid until the next start edge.
- Nominal: a=0x76C, b=0x020, c=0x0A5, single e rising edge -> valid exactly once, 25 cycles after start_edge; y=40'h00_0099_1380; busy high for 25 cycles.
- Max operands: a=b=c=0xFFF -> y=40'h0F_FD00_2FFF. Zero operand: b=0 -> y=0 with valid still pulsed.
- Busy drop: second e rising edge at start_edge+10 -> drop pulses once; the first result is correct; no second valid. Operands changed at the same time do not alter y.
- Async strobe pattern: e toggling at 3/7 ns offsets against a 10 ns clk -> one start_edge per e rising edge, none on falling edges. The count of valid+drop pulses equals the count of e rising edges separated by more than SYNC_STAGES+1 cycles.
- Back-to-back: e rising edge timed so start_edge lands in the first IDLE cycle after DONE -> accepted, no drop, second valid 26 cycles after the first.

Source files
------------

// File: rtl/mul3_seq_ctrl_pkg.sv
// Shared constants for the triple-operand sequencing controller.
// State encoding, default widths and the counter-width helper.
package mul3_seq_ctrl_pkg;

  localparam int W_DEF  = 12;
  localparam int YW_DEF = 40;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL1 = 2'd1,
    S_MUL2 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CW_DEF = cnt_width(W_DEF);

endpackage

// File: rtl/mul3_seq_ctrl_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous strobe plus a one-cycle rising-edge pulse.
// rise is combinational from the last sync flop and one extra delay flop.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      dly  <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~dly;

endmodule

// File: rtl/mul3_seq_ctrl.sv
// Computes y = a*b*c on one shared shift-add multiplier over two W-step passes.
// Start requests arriving while a computation is in flight are dropped and flagged.
module mul3_seq_ctrl
  import mul3_seq_ctrl_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int YW          = YW_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          e,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  output logic [YW-1:0] y,
  output logic          valid,
  output logic          busy,
  output logic          drop
);

  localparam int CW = cnt_width(W);

  state_t           state;
  state_t           state_nxt;
  logic             start_edge;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     c_r;
  logic [2*W-1:0]   acc1;
  logic [2*W-1:0]   acc1_nxt;
  logic [3*W-1:0]   acc2;
  logic [3*W-1:0]   acc2_nxt;
  logic [CW-1:0]    cnt;
  logic             cnt_last;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (e),
    .rise (start_edge)
  );

  assign cnt_last = (cnt == CW'(W - 1));

  // One partial product per step; pass 1 builds a*b, pass 2 multiplies that by c.
  always_comb begin
    acc1_nxt = acc1;
    acc2_nxt = acc2;
    if (b_r[cnt]) acc1_nxt = acc1 + ({{W{1'b0}}, a_r} << cnt);
    if (c_r[cnt]) acc2_nxt = acc2 + ({{W{1'b0}}, acc1} << cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    busy      = (state != S_IDLE);
    drop      = start_edge && (state != S_IDLE);
    case (state)
      S_IDLE: if (start_edge) state_nxt = S_MUL1;
      S_MUL1: if (cnt_last)   state_nxt = S_MUL2;
      S_MUL2: if (cnt_last)   state_nxt = S_DONE;
      S_DONE: begin
        valid     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= '0;
      acc1 <= '0;
      acc2 <= '0;
      cnt  <= '0;
      y    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            a_r  <= a;
            b_r  <= b;
            c_r  <= c;
            acc1 <= '0;
            acc2 <= '0;
            cnt  <= '0;
          end
        end
        S_MUL1: begin
          acc1 <= acc1_nxt;
          cnt  <= cnt_last ? '0 : cnt + 1'b1;
        end
        S_MUL2: begin
          acc2 <= acc2_nxt;
          cnt  <= cnt_last ? '0 : cnt + 1'b1;
          // Load y with the final step folded in so it is already valid in DONE.
          if (cnt_last) y <= YW'(acc2_nxt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul3_seq_ctrl.sv
// Directed self-checking bench for mul3_seq_ctrl; outputs sampled on the falling clock edge.
module tb_mul3_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        e   = 1'b0;
  logic [11:0] a   = '0;
  logic [11:0] b   = '0;
  logic [11:0] c   = '0;
  logic [39:0] y;
  logic        valid;
  logic        busy;
  logic        drop;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int drop_cnt  = 0;

  mul3_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .e     (e),
    .a     (a),
    .b     (b),
    .c     (c),
    .y     (y),
    .valid (valid),
    .busy  (busy),
    .drop  (drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (drop)  drop_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_busy(input string tag);
    int t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " start accepted"}, 64'(busy), 64'd1);
  endtask

  task automatic run_op(input logic [11:0] ta, input logic [11:0] tb_v, input logic [11:0] tc,
                        input logic [39:0] ey, input string tag);
    int busy_len = 0;
    int vpos     = 0;
    int vseen    = 0;
    logic [39:0] yv = '0;
    @(negedge clk);
    a = ta; b = tb_v; c = tc; e = 1'b1;
    wait_busy(tag);
    e = 1'b0;
    while (busy && busy_len < 40) begin
      busy_len++;
      if (valid) begin
        vseen++;
        vpos = busy_len;
        yv   = y;
      end
      @(negedge clk);
    end
    chk({tag, " busy length"}, 64'(busy_len), 64'd25);
    chk({tag, " valid count"}, 64'(vseen), 64'd1);
    chk({tag, " valid position"}, 64'(vpos), 64'd25);
    chk({tag, " y at valid"}, 64'(yv), 64'(ey));
    chk({tag, " y held"}, 64'(y), 64'(ey));
    repeat (4) @(negedge clk);
  endtask

  // Second strobe raised at busy sample k_e of the first computation.
  task automatic pair_run(input int k_e, input int exp_valid, input int exp_drop, input string tag);
    int t1 = 0;
    int t2 = 0;
    int nv = 0;
    int d0;
    logic [39:0] y1 = '0;
    logic [39:0] y2 = '0;
    @(negedge clk);
    a = 12'd3; b = 12'd5; c = 12'd7; e = 1'b1;
    d0 = drop_cnt;
    wait_busy(tag);
    e = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      if (valid) begin
        nv++;
        if (t1 == 0) begin t1 = k; y1 = y; end
        else begin t2 = k; y2 = y; end
      end
      if (k == 26) chk({tag, " idle gap busy"}, 64'(busy), 64'(exp_valid == 2 ? 0 : 0));
      if (k == k_e) begin
        a = 12'h010; b = 12'h010; c = 12'h010; e = 1'b1;
      end
      if (k == k_e + 6) e = 1'b0;
      @(negedge clk);
    end
    chk({tag, " valid count"}, 64'(nv), 64'(exp_valid));
    chk({tag, " drop count"}, 64'(drop_cnt - d0), 64'(exp_drop));
    chk({tag, " first y"}, 64'(y1), 64'h69);
    if (exp_valid == 2) begin
      chk({tag, " valid spacing"}, 64'(t2 - t1), 64'd26);
      chk({tag, " second y"}, 64'(y2), 64'h1000);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int v0;
    int d0;
    int blen;
    int nv;
    logic [39:0] yv;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset y", 64'(y), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset valid", 64'(valid), 64'd0);
    chk("reset drop", 64'(drop), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_op(12'h76C, 12'h020, 12'h0A5, 40'h00_0099_1380, "nominal");
    run_op(12'hFFF, 12'hFFF, 12'hFFF, 40'h0F_FD00_2FFF, "max");
    run_op(12'h5A5, 12'h000, 12'h3C3, 40'h0, "zero b");
    run_op(12'h001, 12'h001, 12'h001, 40'h1, "ones");

    // Busy drop: second strobe ~10 cycles in, with new operands that must be ignored
    @(negedge clk);
    a = 12'h123; b = 12'h456; c = 12'h789; e = 1'b1;
    v0 = valid_cnt; d0 = drop_cnt;
    wait_busy("drop");
    e = 1'b0;
    blen = 0; nv = 0; yv = '0;
    while (busy && blen < 40) begin
      blen++;
      if (valid) begin nv++; yv = y; end
      if (blen == 8) begin a = 12'hFFF; b = 12'hFFF; c = 12'hFFF; e = 1'b1; end
      @(negedge clk);
    end
    chk("drop first y", 64'(yv), 64'h2523_8AD2);
    chk("drop valid in run", 64'(nv), 64'd1);
    repeat (10) @(negedge clk);
    e = 1'b0;
    repeat (40) @(negedge clk);
    chk("drop pulses", 64'(drop_cnt - d0), 64'd1);
    chk("drop no second valid", 64'(valid_cnt - v0), 64'd1);
    chk("drop y held", 64'(y), 64'h2523_8AD2);

    // Back-to-back: strobe lands in first IDLE cycle (accepted) vs in DONE (dropped)
    pair_run(24, 2, 0, "b2b accept");
    repeat (10) @(negedge clk);
    pair_run(23, 1, 1, "b2b in done");
    repeat (10) @(negedge clk);

    // Async strobe at 3/7 ns offsets: four rises, two during busy
    a = 12'd1; b = 12'd2; c = 12'd3;
    v0 = valid_cnt; d0 = drop_cnt;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk); #3 e = 1'b1;
      @(negedge clk); #7 e = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    @(negedge clk); #3 e = 1'b1;
    @(negedge clk); #7 e = 1'b0;
    repeat (40) @(negedge clk);
    chk("async valids", 64'(valid_cnt - v0), 64'd2);
    chk("async drops", 64'(drop_cnt - d0), 64'd2);
    chk("async y", 64'(y), 64'd6);

    // Reset mid-computation during MUL2
    @(negedge clk);
    a = 12'h76C; b = 12'h020; c = 12'h0A5; e = 1'b1;
    wait_busy("midreset");
    e = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset y", 64'(y), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset valid", 64'(valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    v0 = valid_cnt;
    repeat (40) @(negedge clk);
    chk("midreset no valid", 64'(valid_cnt - v0), 64'd0);
    chk("midreset y stays 0", 64'(y), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
